// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types and constants: reset fetch address, the NOP word,
// and the {pc, inst} record carried by IF/ID and later pipeline registers.
package mips_pipe_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo_ctrl.sv
// Pointer/count bookkeeping for the fetch queue. A redirect empties the queue
// and overrides any push or pop requested in the same cycle.
module fetch_fifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic                       id_ready,
  input  logic                       redirect,
  output logic                       push,
  output logic                       full,
  output logic                       not_empty,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  // Full depends on registered count only, keeping id_ready off the PC-stage hazard path.
  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = if_valid & ~full & ~redirect;
  assign pop       = not_empty & id_ready & ~redirect;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch buffer between PC generation and decode: captures {pc, inst}
// each valid cycle, presents the oldest entry to ID, stalls IF when full.
module if_fetch_queue
  import mips_pipe_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = mips_pipe_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [31:0]                if_pc,
  input  logic [31:0]                if_inst,
  input  logic                       redirect,
  input  logic                       id_ready,
  output logic                       stall_if,
  output logic                       id_valid,
  output logic [31:0]                id_pc,
  output logic [31:0]                id_inst,
  output logic [31:0]                id_pc4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  fetch_entry_t  head;
  logic          push;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  fetch_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .id_ready  (id_ready),
    .redirect  (redirect),
    .push      (push),
    .full      (stall_if),
    .not_empty (id_valid),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (occupancy)
  );

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = '{pc: if_pc, inst: if_inst};
  end

  // Every slot is reset so the head mux can never expose an uninitialised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: RESET_PC, inst: NOP_INST};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head    = mem_q[rd_ptr];
  assign id_pc   = id_valid ? head.pc   : RESET_PC;
  assign id_inst = id_valid ? head.inst : NOP_INST;
  assign id_pc4  = id_pc + 32'd4;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed + randomized checks of if_fetch_queue against a queue-based model.
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, redirect, id_ready;
  logic [31:0] if_pc, if_inst;
  logic        stall_if, id_valid;
  logic [31:0] id_pc, id_inst, id_pc4;
  logic [2:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model_q[$];   // {pc, inst}, front = oldest

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .redirect(redirect), .id_ready(id_ready), .stall_if(stall_if), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .id_pc4(id_pc4), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [31:0] e_pc, e_inst;
    int n;
    n      = model_q.size();
    e_pc   = (n != 0) ? model_q[0][63:32] : RST_PC;
    e_inst = (n != 0) ? model_q[0][31:0]  : NOP;
    chk({where, ".occupancy"}, 32'(occupancy), 32'(n));
    chk({where, ".id_valid"},  32'(id_valid),  32'(n != 0));
    chk({where, ".stall_if"},  32'(stall_if),  32'(n == DEPTH));
    chk({where, ".id_pc"},     id_pc,   e_pc);
    chk({where, ".id_inst"},   id_inst, e_inst);
    chk({where, ".id_pc4"},    id_pc4,  e_pc + 32'd4);
  endtask

  // Drive one cycle's inputs, check that outputs don't react combinationally,
  // clock it, advance the model, and check the registered result.
  task automatic cyc(input string tag, input logic v, input logic [31:0] pc,
                     input logic [31:0] inst, input logic red, input logic rdy);
    bit full_now, pop_ok;
    if_valid = v; if_pc = pc; if_inst = inst; redirect = red; id_ready = rdy;
    #1 check_all({tag, ".pre"});
    full_now = (model_q.size() == DEPTH);
    pop_ok   = (model_q.size() != 0) && rdy;
    @(posedge clk);
    if (red) model_q.delete();
    else begin
      if (pop_ok) void'(model_q.pop_front());
      if (v && !full_now) model_q.push_back({pc, inst});
    end
    #1 check_all(tag);
  endtask

  initial begin
    rst = 1'b1; if_valid = 0; if_pc = 0; if_inst = 0; redirect = 0; id_ready = 0;
    #12 check_all("reset");
    @(negedge clk) rst = 1'b0;

    // Fill to full; the fifth fetch must be dropped.
    for (int i = 0; i < 5; i++)
      cyc("fill", 1'b1, RST_PC + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    chk("fill.stall", 32'(stall_if), 32'd1);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      chk("drain.pc", id_pc, RST_PC + 32'(4*i));
      cyc("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end

    // Full + pop + fetch in the same cycle: pop only.
    for (int i = 0; i < 4; i++)
      cyc("refill", 1'b1, 32'h0000_3100 + 32'(4*i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    cyc("fullpop", 1'b1, 32'h0000_3200, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("fullpop.occ", 32'(occupancy), 32'd3);
    chk("fullpop.head", id_pc, 32'h0000_3104);

    // Redirect beats push and pop.
    cyc("red.pre", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc("red.p0", 1'b1, 32'h0000_3010, 32'h1111_1111, 1'b0, 1'b0);
    cyc("red.p1", 1'b1, 32'h0000_3014, 32'h2222_2222, 1'b0, 1'b0);
    cyc("redirect", 1'b1, 32'h0000_3018, 32'h3333_3333, 1'b1, 1'b1);
    chk("redirect.valid", 32'(id_valid), 32'd0);
    cyc("red.next", 1'b1, 32'h0000_3040, 32'h4444_4444, 1'b0, 1'b1);
    chk("redirect.head", id_pc, 32'h0000_3040);
    cyc("red.drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Wrap: one primed entry, then ten simultaneous push/pop pairs.
    cyc("wrap.prime", 1'b1, 32'h0000_4000, 32'hC000_0000, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      cyc("wrap", 1'b1, 32'h0000_4000 + 32'(4*i), 32'hC000_0000 + 32'(i), 1'b0, 1'b1);
    chk("wrap.occ", 32'(occupancy), 32'd1);
    chk("wrap.head", id_pc, 32'h0000_4028);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));

    // Async reset mid-run with 3 entries held.
    cyc("rst.redir", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("rst.fill", 1'b1, 32'h0000_5000 + 32'(4*i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
    chk("rst.before", 32'(occupancy), 32'd3);
    if_valid = 0;
    #2 rst = 1'b1;
    model_q.delete();
    #1 check_all("rst.async");
    @(negedge clk) rst = 1'b0;
    cyc("rst.after", 1'b1, 32'h0000_6000, 32'h5555_5555, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
